// File: rtl/rv32_divider_iterative.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow resolve at accept; others take 32 steps plus a sign fix-up.
module rv32_divider_iterative #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            startD,
  input  logic [1:0]      div_opcode,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            abort,
  output logic            busy,
  output logic            doneD,
  output logic [XLEN-1:0] result_divide
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic             is_rem;
  logic             neg_q;
  logic             neg_r;
  logic [XLEN-1:0]  dq;        // dividend shifts out of the top, quotient bits shift in at the bottom
  logic [XLEN-1:0]  divisor;
  logic [XLEN-1:0]  rem;
  logic [CNT_W-1:0] count;

  logic            is_signed;
  logic            sign1;
  logic            sign2;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic            div_zero;
  logic            overflow;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   rem_sub;
  logic            fits;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  always_comb begin
    is_signed = ~div_opcode[0];
    sign1     = is_signed & operand1[XLEN-1];
    sign2     = is_signed & operand2[XLEN-1];
    abs1      = sign1 ? -operand1 : operand1;
    abs2      = sign2 ? -operand2 : operand2;
    div_zero  = (operand2 == '0);
    overflow  = is_signed && (operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (operand2 == '1);
  end

  // Remainder is always below the divisor, so a borrow out of the XLEN+1 bit subtract means "does not fit".
  always_comb begin
    rem_shift = {rem, dq[XLEN-1]};
    rem_sub   = rem_shift - {1'b0, divisor};
    fits      = ~rem_sub[XLEN];
    q_fix     = neg_q ? -dq : dq;
    r_fix     = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      doneD         <= 1'b0;
      result_divide <= '0;
      is_rem        <= 1'b0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      dq            <= '0;
      divisor       <= '0;
      rem           <= '0;
      count         <= '0;
    end else begin
      doneD <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (startD && !abort) begin
            is_rem  <= div_opcode[1];
            neg_q   <= sign1 ^ sign2;
            neg_r   <= sign1;
            dq      <= abs1;
            divisor <= abs2;
            rem     <= '0;
            count   <= '0;
            if (div_zero) begin
              result_divide <= div_opcode[1] ? operand1 : '1;
              state         <= DONE;
              doneD         <= 1'b1;
            end else if (overflow) begin
              result_divide <= div_opcode[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
              state         <= DONE;
              doneD         <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end
        end
        CALC: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            rem   <= fits ? rem_sub[XLEN-1:0] : rem_shift[XLEN-1:0];
            dq    <= {dq[XLEN-2:0], fits};
            count <= count + 1'b1;
            if (count == LAST_STEP) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          busy <= 1'b0;
          if (abort) begin
            state <= IDLE;
          end else begin
            result_divide <= is_rem ? r_fix : q_fix;
            state         <= DONE;
            doneD         <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_divider_iterative.sv
// Directed bench for rv32_divider_iterative: a cycle-indexed reference model is checked
// against doneD, busy and result_divide on every falling edge.
module tb_rv32_divider_iterative;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        startD;
  logic [1:0]  div_opcode;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        abort;
  logic        busy;
  logic        doneD;
  logic [31:0] result_divide;

  rv32_divider_iterative #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .startD        (startD),
    .div_opcode    (div_opcode),
    .operand1      (operand1),
    .operand2      (operand2),
    .abort         (abort),
    .busy          (busy),
    .doneD         (doneD),
    .result_divide (result_divide)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;

  // Model state: expected completion cycle, busy window and the held result.
  bit          armed = 0;
  bit          pend = 0;
  int          due = 0;
  int          busy_lo = 1;
  int          busy_hi = 0;
  logic [31:0] pend_res = '0;
  logic [31:0] held = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  always @(negedge clk) begin
    if (rst && armed) begin
      logic exp_done;
      logic exp_busy;
      exp_done = pend && (cyc == due);
      if (exp_done) begin
        held = pend_res;
        pend = 0;
      end
      exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      check("doneD", {31'b0, doneD}, {31'b0, exp_done});
      check("busy", {31'b0, busy}, {31'b0, exp_busy});
      check("result_divide", result_divide, held);
    end
  end

  // Drive one cycle of startD/abort; the model decides acceptance from the busy window.
  task automatic issue(input bit st, input bit ab, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    bit busy_now;
    busy_now   = (cyc >= busy_lo) && (cyc <= busy_hi);
    startD     = st;
    abort      = ab;
    div_opcode = op;
    operand1   = a;
    operand2   = b;
    if (st && !ab && !busy_now) begin
      pend     = 1;
      pend_res = ref_div(op, a, b);
      if (is_special(op, a, b)) begin
        due     = cyc + 1;
        busy_lo = 1;
        busy_hi = 0;
      end else begin
        due     = cyc + 34;
        busy_lo = cyc + 1;
        busy_hi = cyc + 33;
      end
    end else if (ab && busy_now) begin
      pend    = 0;
      busy_hi = cyc;
    end
    @(negedge clk);
    #1;
    startD = 1'b0;
    abort  = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] lit);
    check("model", ref_div(op, a, b), lit);
    issue(1, 0, op, a, b);
    wait_until(due + 2);
  endtask

  initial begin
    rst        = 1'b0;
    startD     = 1'b0;
    abort      = 1'b0;
    div_opcode = 2'b00;
    operand1   = '0;
    operand2   = '0;
    #2;
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, doneD}, 32'h0);
    check("reset_result", result_divide, 32'h0);
    @(negedge clk);
    #1;
    rst   = 1'b1;
    armed = 1;

    run(OP_DIV,  32'h0000_0014, 32'hFFFF_FFFD, 32'hFFFF_FFFA);
    run(OP_REM,  32'h0000_0014, 32'hFFFF_FFFD, 32'h0000_0002);
    run(OP_REM,  32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE);
    run(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF);
    run(OP_REMU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F);
    run(OP_DIV,  32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF);
    run(OP_REMU, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007);
    run(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    run(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

    // Start while busy is ignored.
    check("model", ref_div(OP_DIV, 32'd100, 32'd7), 32'd14);
    check("model", ref_div(OP_DIVU, 32'd100, 32'd7), 32'd14);
    issue(1, 0, OP_DIV, 32'd100, 32'd7);
    wait_until(due - 30);
    issue(1, 0, OP_DIVU, 32'd100, 32'd7);
    wait_until(due + 2);

    // Back-to-back accept in the DONE cycle.
    check("model", ref_div(OP_DIVU, 32'd1000, 32'd10), 32'd100);
    check("model", ref_div(OP_REM, 32'hFFFF_FC18, 32'd7), 32'hFFFF_FFFA);
    issue(1, 0, OP_DIVU, 32'd1000, 32'd10);
    wait_until(due);
    issue(1, 0, OP_REM, 32'hFFFF_FC18, 32'd7);
    wait_until(due + 2);

    // abort together with startD in IDLE: nothing accepted.
    issue(1, 1, OP_DIV, 32'd50, 32'd5);
    repeat (4) begin
      @(negedge clk);
      #1;
    end

    // abort at CALC step 10.
    issue(1, 0, OP_DIV, 32'd100, 32'd7);
    wait_until(due - 24);
    issue(0, 1, OP_DIV, 32'd0, 32'd0);
    repeat (40) begin
      @(negedge clk);
      #1;
    end

    // Asynchronous reset mid-CALC.
    issue(1, 0, OP_DIV, 32'd100, 32'd7);
    wait_until(due - 20);
    #2;
    armed = 0;
    rst   = 1'b0;
    #1;
    check("async_rst_busy", {31'b0, busy}, 32'h0);
    check("async_rst_done", {31'b0, doneD}, 32'h0);
    check("async_rst_result", result_divide, 32'h0);
    pend    = 0;
    held    = '0;
    busy_lo = 1;
    busy_hi = 0;
    @(negedge clk);
    #1;
    rst   = 1'b1;
    armed = 1;

    run(OP_DIVU, 32'd9, 32'd2, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_divider_iterative.md
Name: rv32_divider_iterative

Overview:
- Radix-2 restoring divider serving the M-extension controller. It is the responder side of the startD / div_opcode / operand1 / operand2 → doneD / result_divide handshake.
- Sits beside the iterative multiplier in the execute stage.
- Accepts one DIV/DIVU/REM/REMU request, computes over 32 iterations, and returns a one-cycle done pulse with a held result.
- Resolves RISC-V divide-by-zero and signed-overflow cases in a single cycle.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; the iteration counter is clog2(XLEN)+1 bits.

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately)
- startD  input  1  request strobe; sampled only when the unit can accept
- div_opcode  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with startD
- operand1  input  XLEN  dividend; sampled with startD
- operand2  input  XLEN  divisor; sampled with startD
- abort  input  1  pipeline flush; cancels any in-flight operation
- busy  output  1  high in CALC and FIX
- doneD  output  1  one-cycle pulse: result_divide is valid
- result_divide  output  XLEN  quotient or remainder; held until the next accepted start

Behaviour:
- Reset (rst=0, async) forces:
  - state=IDLE, busy=0, doneD=0, result_divide=0, all internal registers 0.
  - Reset mid-operation discards the operation with no doneD.
- State IDLE:
  - Accept when startD=1 and abort=0.
  - Latch the opcode, the sign flags, and |operand1|, |operand2|. Absolute values apply only for signed opcodes (00, 10); unsigned opcodes take the operands as-is.
- Special cases, decided at the accept edge, go straight to DONE with result_divide loaded on that edge, so doneD is high in the next cycle (latency 1):
  - operand2==0:
    - DIV/DIVU → all ones (0xFFFFFFFF)
    - REM/REMU → operand1
  - Signed overflow, DIV/REM only, with operand1==0x80000000 and operand2==0xFFFFFFFF:
    - DIV → 0x80000000
    - REM → 0
  - Divide-by-zero has priority over overflow.
- Normal accept → CALC, count=0.
- CALC: one restoring step per edge.
  - remainder = {remainder, dividend MSB} shifted left.
  - If remainder ≥ divisor: subtract and shift in a quotient bit of 1; otherwise shift in 0.
  - After the 32nd step (count==31 at the edge), go to FIX.
- FIX: one edge.
  - Quotient is negated if the two signs differ (signed ops).
  - Remainder is negated if the dividend was negative (signed ops).
  - result_divide takes the quotient (DIV/DIVU) or the remainder (REM/REMU); go to DONE.
- DONE:
  - doneD=1 for exactly this cycle; busy=0.
  - Next edge → IDLE, or directly accept a new startD (back-to-back; DONE behaves as IDLE for acceptance).
- Normal latency:
  - Accept edge E0; CALC steps on E1..E32; FIX on E33; doneD high in the cycle after E33.
  - This gives 34 cycles from accept edge to doneD.
- startD while busy=1 is ignored: no queueing, and the in-flight operands are unaffected.
- abort:
  - When high at an edge in CALC/FIX/DONE → IDLE; doneD is not produced (or is dropped).
  - result_divide keeps its previous value.
  - abort and startD together in IDLE: abort wins, nothing is accepted.
- Remainder datapath is XLEN+1 bits so the compare/subtract never overflows; the quotient is XLEN bits.
- Outputs are registered only; there is no combinational path from inputs to doneD or result_divide.

Test Plan:
- DIV 20 / -3 (0x14, 0xFFFFFFFD) → doneD exactly 34 cycles after the accept edge, result 0xFFFFFFFA. Repeat with REM → 0x00000002.
- REM -20 / 3 → 0xFFFFFFFE. DIVU 0xFFFFFFFF / 0x10 → 0x0FFFFFFF. REMU with the same operands → 0x0000000F.
- Divide by zero:
  - DIV 7 / 0 → 0xFFFFFFFF with doneD in the cycle after accept.
  - REMU 7 / 0 → 0x00000007.
  - busy stays 0 throughout.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 (latency 1). REM with the same operands → 0x00000000. DIVU with the same operands takes the normal 34-cycle path → 0x00000000.
- Busy behaviour:
  - Second startD (DIVU 100/7) at cycle 5 of an in-flight DIV 100/7 → ignored; a single doneD, result 14.
  - startD asserted in the DONE cycle → accepted back-to-back; the next doneD follows 34 cycles later.
- Cancellation:
  - abort at CALC step 10 → busy=0 on the next cycle, no doneD, result_divide unchanged.
  - rst driven low asynchronously mid-CALC → busy, doneD and result_divide go to 0 immediately, without waiting for a clock edge.
